// File: rtl/sync_debounce_p.sv
`default_nettype none
// ============================================================================
// sync_debounce_p -- debounce filter, rise/fall pulses, saturating glitch count
// Rev 1.0
// ============================================================================
module sync_debounce_p #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5,
  parameter int GLITCH_W   = 8
) (
  input  logic                clki,
  input  logic                rstn,
  input  logic                sync_data_i,
  input  logic                clr_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  typedef enum logic [1:0] {
    ST_HIGH  = 2'd0,
    CHK_LOW  = 2'd1,
    ST_LOW   = 2'd2,
    CHK_HIGH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             glitch_evt;

  // A reversal while a check is pending is the only way a glitch is recorded.
  assign glitch_evt = ((state == CHK_LOW)  &&  sync_data_i) ||
                      ((state == CHK_HIGH) && !sync_data_i);

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_HIGH;
      cnt     <= '0;
      level_o <= 1'b1;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      case (state)
        ST_HIGH: begin
          if (!sync_data_i) begin
            state <= CHK_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CHK_LOW: begin
          if (sync_data_i) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_LOW;
            cnt     <= '0;
            level_o <= 1'b0;
            fall_o  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOW: begin
          if (sync_data_i) begin
            state <= CHK_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CHK_HIGH: begin
          if (!sync_data_i) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_HIGH;
            cnt     <= '0;
            level_o <= 1'b1;
            rise_o  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_HIGH;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Clear has priority over a coincident glitch event.
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      glitch_cnt_o <= '0;
    end else if (clr_i) begin
      glitch_cnt_o <= '0;
    end else if (glitch_evt && (glitch_cnt_o != GLITCH_MAX)) begin
      glitch_cnt_o <= glitch_cnt_o + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce_p.sv
`default_nettype none
// ============================================================================
// tb_sync_debounce_p -- directed and random checks for sync_debounce_p
// Rev 1.0
// ============================================================================
module tb_sync_debounce_p;

  localparam int DEB  = 4;
  localparam int CW   = 3;
  localparam int GW   = 2;
  localparam int GMAX = (1 << GW) - 1;

  logic          clki = 1'b0;
  logic          rstn;
  logic          sync_data_i;
  logic          clr_i;
  logic          level_o;
  logic          rise_o;
  logic          fall_o;
  logic [GW-1:0] glitch_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clki = ~clki;

  sync_debounce_p #(
    .DEB_CYCLES (DEB),
    .CNT_W      (CW),
    .GLITCH_W   (GW)
  ) dut (
    .clki         (clki),
    .rstn         (rstn),
    .sync_data_i  (sync_data_i),
    .clr_i        (clr_i),
    .level_o      (level_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .glitch_cnt_o (glitch_cnt_o)
  );

  // Reference: count samples differing from the accepted level.
  logic m_lvl, m_rise, m_fall;
  int   m_run, m_gcnt;

  always @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      m_lvl  <= 1'b1;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      m_run  <= 0;
      m_gcnt <= 0;
    end else begin
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      if (sync_data_i != m_lvl) begin
        if (m_run == DEB - 1) begin
          m_lvl  <= sync_data_i;
          m_rise <= sync_data_i;
          m_fall <= ~sync_data_i;
          m_run  <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      if (clr_i)
        m_gcnt <= 0;
      else if (sync_data_i == m_lvl && m_run != 0 && m_gcnt < GMAX)
        m_gcnt <= m_gcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive on the falling edge, let the rising edge sample, return on the next falling edge.
  task automatic tick(input logic d, input logic clr);
    sync_data_i = d;
    clr_i       = clr;
    @(posedge clki);
    @(negedge clki);
  endtask

  int glitch_exp [5] = '{1, 2, 3, 3, 3};
  logic d;

  initial begin
    rstn        = 1'b0;
    sync_data_i = 1'b1;
    clr_i       = 1'b0;
    @(negedge clki);
    @(negedge clki);
    check("rst_level", level_o, 1);
    check("rst_rise", rise_o, 0);
    check("rst_fall", fall_o, 0);
    check("rst_gcnt", glitch_cnt_o, 0);
    rstn = 1'b1;

    // Steady high: nothing happens.
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'b0);
      check("idle_pulse", {rise_o, fall_o}, 0);
    end
    check("idle_level", level_o, 1);
    check("idle_gcnt", glitch_cnt_o, 0);

    // Accepted fall after 4 low samples, then accepted rise after 4 high samples.
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 1'b0);
      check("fall_wait_lvl", level_o, 1);
      check("fall_wait_pls", fall_o, 0);
    end
    tick(1'b0, 1'b0);
    check("fall_lvl", level_o, 0);
    check("fall_pls", fall_o, 1);
    check("fall_norise", rise_o, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b0);
      check("fall_one_cycle", fall_o, 0);
      check("rise_wait_lvl", level_o, 0);
      check("rise_wait_pls", rise_o, 0);
    end
    tick(1'b1, 1'b0);
    check("rise_lvl", level_o, 1);
    check("rise_pls", rise_o, 1);
    tick(1'b1, 1'b0);
    check("rise_one_cycle", rise_o, 0);

    // Low glitches of 1, 2 and 3 samples are rejected and counted.
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w; i++) begin
        tick(1'b0, 1'b0);
        check("glitch_nofall", fall_o, 0);
        check("glitch_lvl", level_o, 1);
      end
      tick(1'b1, 1'b0);
      check("glitch_cnt", glitch_cnt_o, w);
      for (int i = 0; i < 9; i++) begin
        tick(1'b1, 1'b0);
        check("glitch_gap", {rise_o, fall_o, level_o}, 1);
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("wide_fall", fall_o, 1);
    check("wide_lvl", level_o, 0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("wide_rise", rise_o, 1);
    check("wide_gcnt", glitch_cnt_o, 3);

    // Clear, then saturation, then clear colliding with a glitch event.
    tick(1'b1, 1'b1);
    check("clr_gcnt", glitch_cnt_o, 0);
    for (int g = 0; g < 5; g++) begin
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      check("sat_gcnt", glitch_cnt_o, glitch_exp[g]);
      tick(1'b1, 1'b0);
    end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("clr_wins", glitch_cnt_o, 0);
    tick(1'b1, 1'b0);
    check("clr_hold", glitch_cnt_o, 0);

    // Reset after two low samples discards the partial count.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("rchk_lvl", level_o, 1);
    check("rchk_pls", {rise_o, fall_o}, 0);
    @(negedge clki);
    check("rchk_hold_pls", {rise_o, fall_o}, 0);
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 1'b0);
      check("rchk_restart", fall_o, 0);
    end
    tick(1'b0, 1'b0);
    check("rchk_fall", fall_o, 1);
    check("rchk_fall_lvl", level_o, 0);
    tick(1'b0, 1'b0);

    // Reset while low forces level high at once, with no rise pulse.
    #2 rstn = 1'b0;
    #1;
    check("rlow_lvl", level_o, 1);
    check("rlow_pls", {rise_o, fall_o}, 0);
    check("rlow_gcnt", glitch_cnt_o, 0);
    @(negedge clki);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      check("rlow_after", {rise_o, fall_o, level_o}, 1);
    end

    // Random toggling against the reference model.
    rstn = 1'b0;
    @(negedge clki);
    rstn = 1'b1;
    d = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 4) == 0) d = ~d;
      tick(d, ($urandom_range(0, 63) == 0));
      check("rnd_level", level_o, m_lvl);
      check("rnd_rise", rise_o, m_rise);
      check("rnd_fall", fall_o, m_fall);
      check("rnd_gcnt", glitch_cnt_o, m_gcnt);
      check("rnd_excl", rise_o & fall_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_debounce_p.md
# sync_debounce_p

Debounce filter and edge detector placed directly downstream of the single-bit synchronizer, in the same clock domain. It consumes the already-synchronized level, which resets high, and accepts a level change only after it has held for DEB_CYCLES consecutive clocks. It produces a clean level, one-cycle rise/fall pulses and a saturating count of rejected glitches for status registers.

## Interface
- DEB_CYCLES, 16, consecutive identical samples needed to accept a level change; legal range 2 .. 2^CNT_W-1
- CNT_W, 5, debounce counter width
- GLITCH_W, 8, glitch counter width
- clki  in  1  clock; one clock domain, all logic on rising edge
- rstn  in  1  reset, asynchronous assert, active-low; all state returns to reset values immediately
- sync_data_i  in  1  synchronized input level (synchronizer output, reset-high)
- clr_i  in  1  synchronous clear of glitch_cnt_o
- level_o  out  1  debounced level, registered
- rise_o  out  1  one-cycle pulse, accepted 0->1 transition
- fall_o  out  1  one-cycle pulse, accepted 1->0 transition
- glitch_cnt_o  out  GLITCH_W  rejected transitions, saturating

## Operation
- FSM states: ST_HIGH (reset), CHK_LOW, ST_LOW, CHK_HIGH.
- ST_HIGH:
  - sync_data_i=0 -> CHK_LOW, cnt=1.
  - Otherwise hold, cnt=0.
- CHK_LOW:
  - sync_data_i=0 and cnt=DEB_CYCLES-1 -> ST_LOW, level_o=0, fall_o=1 for one cycle, cnt=0.
  - sync_data_i=0 and cnt<DEB_CYCLES-1 -> cnt+1.
  - sync_data_i=1 -> ST_HIGH, cnt=0, glitch event.
- ST_LOW and CHK_HIGH mirror ST_HIGH and CHK_LOW with polarity swapped; acceptance sets level_o=1 and rise_o=1.
- level_o changes only on accepted transitions. In CHK_* states it holds the previous stable value.
- rise_o and fall_o are never high together and never high in consecutive cycles.
- Glitch counter:
  - Increments by 1 on each glitch event.
  - Saturates at 2^GLITCH_W-1 with no wrap.
  - clr_i=1 loads 0. If clr_i coincides with a glitch event, the clear wins and the result is 0.
- Reset values: state ST_HIGH, cnt 0, level_o 1, rise_o 0, fall_o 0, glitch_cnt_o 0.
- Reset mid-check (CHK_*): the partial count is discarded and no pulse is generated. After release, a low input restarts counting from 1.
- Reset while in ST_LOW: level_o goes to 1 asynchronously and no rise_o pulse is issued.

## Timing
- Define edge 0 as the last edge sampling the old level, and edges 1..N as those sampling the new level.
- With the input steady from edge 1, the transition is accepted at edge DEB_CYCLES. level_o and the pulse are visible after edge DEB_CYCLES.
  - Latency from the sync_data_i change is DEB_CYCLES clocks.
  - End-to-end from the asynchronous pin is STAGE + DEB_CYCLES.
- A reversal sampled at any edge 2..DEB_CYCLES aborts the check. The glitch count is visible the following cycle.
- A glitch exactly DEB_CYCLES-1 samples wide is rejected. One exactly DEB_CYCLES wide is accepted.
- Immediate re-toggle after acceptance: the opposite check starts at the next edge, so the minimum spacing between fall_o and rise_o is DEB_CYCLES clocks.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset, then hold sync_data_i=1 for 50 cycles (DEB_CYCLES=4) -> level_o=1, no pulses, glitch_cnt_o=0.
- Drive sync_data_i low at edge 1 and hold -> fall_o high exactly one cycle after edge 4, level_o=0 from edge 4; then drive high -> rise_o after the 4th high sample, level_o=1.
- Low pulses of 1, 2 and 3 samples separated by 10 high cycles -> no fall_o, level_o stays 1, glitch_cnt_o=3; then a 4-sample low pulse -> fall_o once.
- GLITCH_W=2, five 1-sample glitches -> glitch_cnt_o reads 1,2,3,3,3; then assert clr_i in the same cycle as a 6th glitch event -> glitch_cnt_o=0.
- Assert rstn low during CHK_LOW after 2 low samples and again while in ST_LOW -> level_o=1 immediately, rise_o/fall_o stay 0; after release with the input low, fall_o arrives 4 samples later.
- Random toggling for 10k cycles against a reference model -> level_o, pulses and counter match every cycle; rise_o and fall_o are never both asserted.
